// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: pipelined imem read initiator with prefetch FIFO and redirect flush.
// Optional build macro IFU_ALIGN_CHECK_EN adds the sticky fetch_misaligned flag.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef IFU_ALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {FETCH, FLUSH} state_t;

    state_t         state_reg, state_next;
    logic           run_reg;
    logic [31:0]    fetch_pc_reg;
    logic [OW-1:0]  outstanding_reg, outstanding_next;
    logic [OW-1:0]  discard_reg, discard_next;
    logic [AW:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]    fifo_count;
    logic [QW-1:0]  pcq_wr_reg, pcq_rd_reg;

    logic [31:0]    fifo_pc_mem    [FIFO_DEPTH];
    logic [31:0]    fifo_instr_mem [FIFO_DEPTH];
    logic [31:0]    pcq_mem        [MAX_OUTSTANDING];

    logic           redir;
    logic [31:0]    redir_target;
    logic           grant, rsp, pop, push;
    logic           fifo_empty, fifo_full;

`ifdef IFU_ALIGN_CHECK_EN
    logic misaligned_reg;
    assign redir         = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_target  = redirect_pc;
    assign fetch_misaligned = misaligned_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misaligned_reg <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
            misaligned_reg <= 1'b1;
    end
`else
    assign redir        = redirect_valid;
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A response with nothing in flight is a protocol error and is ignored.
    assign rsp   = imem_rvalid && (outstanding_reg != '0);
    assign grant = imem_req && imem_gnt;
    assign pop   = if_valid && if_ready;
    assign push  = rsp && (discard_reg == '0) && !redir && (!fifo_full || pop);

    assign outstanding_next = outstanding_reg + OW'(grant) - OW'(rsp);

    always_comb begin
        discard_next = discard_reg;
        if (redir)
            discard_next = outstanding_reg - OW'(rsp);
        else if (rsp && (discard_reg != '0))
            discard_next = discard_reg - OW'(1);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= FETCH;
        else
            state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:   if (redir && (discard_next != '0)) state_next = FLUSH;
            FLUSH:   if (discard_next == '0)            state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // FSM: outputs; occupancy check reserves a FIFO slot for every request in flight
    always_comb begin
        imem_req = 1'b0;
        if (run_reg && (state_reg == FETCH) && !redir &&
            (int'(outstanding_reg) < MAX_OUTSTANDING) &&
            ((int'(fifo_count) + int'(outstanding_reg)) < FIFO_DEPTH))
            imem_req = 1'b1;
    end

    assign imem_addr = fetch_pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg         <= 1'b0;
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            pcq_wr_reg      <= '0;
            pcq_rd_reg      <= '0;
        end else begin
            run_reg         <= 1'b1;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            if (redir)
                fetch_pc_reg <= redir_target;
            else if (grant)
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (redir)
                rd_ptr_reg <= wr_ptr_reg;
            else if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (grant)
                pcq_wr_reg <= (pcq_wr_reg == QW'(MAX_OUTSTANDING - 1)) ? '0 : pcq_wr_reg + 1'b1;
            if (rsp)
                pcq_rd_reg <= (pcq_rd_reg == QW'(MAX_OUTSTANDING - 1)) ? '0 : pcq_rd_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (grant)
            pcq_mem[pcq_wr_reg] <= fetch_pc_reg;
        if (push) begin
            fifo_pc_mem[wr_ptr_reg[AW-1:0]]    <= pcq_mem[pcq_rd_reg];
            fifo_instr_mem[wr_ptr_reg[AW-1:0]] <= imem_rdata;
        end
    end

    assign if_valid = !fifo_empty;
    assign if_pc    = fifo_empty ? 32'h0 : fifo_pc_mem[rd_ptr_reg[AW-1:0]];
    assign if_instr = fifo_empty ? 32'h0 : fifo_instr_mem[rd_ptr_reg[AW-1:0]];

endmodule
